cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//   Fetch/execute control for the 4-bit CPU. Drives the program ROM address from its program
//   counter and latches the returned instruction into an instruction register (IR).
//   Decodes the IR and updates a 4-bit accumulator, the flags and the PC.
//   Sits directly upstream of the program ROM (addr) and consumes its data (out).
// PARAMETERS
//   AW        3   ROM address / PC width; PC wraps modulo 2**AW
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous, active-low reset
//   en         in   1   1 = sequencer advances; 0 = all state holds (freeze)
//   rom_addr   out  AW  ROM address; equals PC at all times (registered)
//   rom_data   in   4   instruction from ROM, combinational from rom_addr
//   acc        out  4   accumulator A
//   zero       out  1   Z flag
//   carry      out  1   C flag
//   out_data   out  4   value captured by OUT
//   out_valid  out  1   1-cycle pulse when out_data updates
//   halted     out  1   1 once HALT executed; cleared only by reset
// BEHAVIOUR
//   Reset values: PC=RESET_PC, IR=0, A=0, Z=1, C=0, out_data=0, out_valid=0, halted=0, state=FETCH.
//   FSM states:
//   - FETCH: on clock edge with en=1, IR<=rom_data, then -> EXEC.
//   - EXEC: on clock edge with en=1, execute IR, then -> FETCH, or -> HALT for opcode 1111.
//   - HALT: terminal; PC, A and flags hold; halted=1.
//   Each instruction takes 2 cycles. en=0 in any state freezes the state and all registers.
//   out_valid is forced to 0 on any cycle where it is not being pulsed, including en=0 cycles.
//   PC update in EXEC is PC+1 (mod 2**AW) unless stated otherwise.
//   ISA (IR):
//   - 0000 NOP.
//   - 0001 INC: A<=A+1; C<=carry-out (15->0 gives C=1); Z<=(result==0).
//   - 0010 DEC: A<=A-1; C<=borrow (0->15 gives C=1); Z updated.
//   - 0011 CLR: A<=0; Z<=1; C<=0.
//   - 0100 NOT: A<=~A; Z updated; C unchanged.
//   - 0101 SHL: A<={A[2:0],0}; C<=A[3]; Z updated.
//   - 0110 OUT: out_data<=A; out_valid=1 for exactly the cycle after the EXEC edge.
//     Flags unchanged.
//   - 0111 SKZ: if Z then PC<=PC+2 (mod), else PC+1. Flags unchanged.
//   - 1ttt JMP: PC<={zero-extend}ttt (t=000..110). With AW<3, upper target bits are truncated.
//   - 1111 HALT: PC not incremented; state->HALT; halted<=1 on the same edge.
//   - Flags are updated only where listed.
//   Boundary conditions:
//   - PC wrap: last address +1 -> 0.
//   - SKZ at last or second-to-last address wraps the same way.
//   - Reset asserted mid-instruction (either state) clears all state immediately, asynchronously.
//     A fetched-but-unexecuted instruction is discarded.
//   - rom_data is sampled only at the FETCH edge; changes during EXEC are ignored.
// TESTING
//   1. Real program ROM (0:0001, 1..5:1111), en=1:
//      after edge 2 A=1,Z=0,PC=1; after edge 4 halted=1, PC=1, A=1; further edges: no change.
//   2. Bench ROM {0:0011,1:0010,2:0110,3:1111}:
//      A=15, C=1 after DEC; out_valid single-cycle pulse with out_data=15; then halted.
//   3. Bench ROM {0:0001, 1:1000}, A run 16 INCs via JMP loop:
//      A wraps 15->0 with C=1,Z=1 on the 16th INC; PC cycles 0,1,0,...
//   4. SKZ: ROM {0:0011,1:0111,2:0001,3:0110,4:1111}:
//      INC skipped, out_data=0. Repeat with 0011 replaced by 0001: out_data=2.
//   5. Toggle en low for 3 cycles in FETCH and in EXEC:
//      all outputs frozen, out_valid=0 during the freeze; final results identical to the en=1 run.
//   6. Assert rst_n low between the FETCH and EXEC edges of INC, mid-clock:
//      A, PC and IR are 0 immediately; after release, the program restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - ROM, control and result bundle for the 4-bit CPU sequencer
// master: sequencer side (drives rom_addr and results, consumes en and rom_data)
// slave : environment side (program ROM, run control, result observer)
//   en         1   advance enable; 0 freezes the sequencer
//   rom_addr   AW  program ROM address (the PC)
//   rom_data   4   instruction returned by the ROM for rom_addr
//   acc        4   accumulator A
//   zero       1   Z flag
//   carry      1   C flag
//   out_data   4   value captured by OUT
//   out_valid  1   one-cycle pulse when out_data updates
//   halted     1   set once HALT has executed
interface cpu_sequencer_if #(
    parameter int AW = 3
);
    logic          en;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data;
    logic [3:0]    acc;
    logic          zero;
    logic          carry;
    logic [3:0]    out_data;
    logic          out_valid;
    logic          halted;

    modport master (
        input  en, rom_data,
        output rom_addr, acc, zero, carry, out_data, out_valid, halted
    );

    modport slave (
        output en, rom_data,
        input  rom_addr, acc, zero, carry, out_data, out_valid, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute control for the 4-bit CPU
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cpu_sequencer_if.master: en, rom_data in; rom_addr, acc, zero, carry,
//          out_data, out_valid, halted out
// Parameters:
//   AW        PC / ROM address width, PC wraps modulo 2**AW
//   RESET_PC  PC value loaded on reset
module cpu_sequencer #(
    parameter int AW       = 3,
    parameter int RESET_PC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_sequencer_if.master       bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [3:0]    r_ir;
    logic [3:0]    r_acc;
    logic          r_z;
    logic          r_c;
    logic [3:0]    r_out_data;
    logic          r_out_valid;
    logic          r_halted;

    state_t        w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic [3:0]    w_ir_nxt;
    logic [3:0]    w_acc_nxt;
    logic          w_z_nxt;
    logic          w_c_nxt;
    logic [3:0]    w_out_data_nxt;
    logic          w_out_valid_nxt;
    logic          w_halted_nxt;

    logic [AW-1:0] w_pc_inc1;
    logic [AW-1:0] w_pc_inc2;
    logic [AW-1:0] w_jmp_target;
    logic [4:0]    w_sum;
    logic [4:0]    w_diff;

    // Adding in AW bits gives the modulo-2**AW wrap for free.
    assign w_pc_inc1    = r_pc + AW'(1);
    assign w_pc_inc2    = r_pc + AW'(2);
    // Cast zero-extends the 3-bit target, or drops upper bits when AW < 3.
    assign w_jmp_target = AW'(r_ir[2:0]);
    // Bit 4 is the carry-out of INC and the borrow of DEC.
    assign w_sum        = {1'b0, r_acc} + 5'd1;
    assign w_diff       = {1'b0, r_acc} - 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= AW'(RESET_PC);
            r_ir        <= 4'd0;
            r_acc       <= 4'd0;
            r_z         <= 1'b1;
            r_c         <= 1'b0;
            r_out_data  <= 4'd0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_acc       <= w_acc_nxt;
            r_z         <= w_z_nxt;
            r_c         <= w_c_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_acc_nxt       = r_acc;
        w_z_nxt         = r_z;
        w_c_nxt         = r_c;
        w_out_data_nxt  = r_out_data;
        w_halted_nxt    = r_halted;
        // The pulse drops on every edge it is not being raised, frozen or not.
        w_out_valid_nxt = 1'b0;

        if (bus.en) begin
            unique case (r_state)
                FETCH: begin
                    w_ir_nxt    = bus.rom_data;
                    w_state_nxt = EXEC;
                end
                EXEC: begin
                    w_state_nxt = FETCH;
                    w_pc_nxt    = w_pc_inc1;
                    if (r_ir[3]) begin
                        if (r_ir[2:0] == 3'b111) begin
                            w_pc_nxt     = r_pc;
                            w_state_nxt  = HALT;
                            w_halted_nxt = 1'b1;
                        end else begin
                            w_pc_nxt = w_jmp_target;
                        end
                    end else begin
                        unique case (r_ir[2:0])
                            3'b000: ;
                            3'b001: begin
                                w_acc_nxt = w_sum[3:0];
                                w_c_nxt   = w_sum[4];
                                w_z_nxt   = (w_sum[3:0] == 4'd0);
                            end
                            3'b010: begin
                                w_acc_nxt = w_diff[3:0];
                                w_c_nxt   = w_diff[4];
                                w_z_nxt   = (w_diff[3:0] == 4'd0);
                            end
                            3'b011: begin
                                w_acc_nxt = 4'd0;
                                w_z_nxt   = 1'b1;
                                w_c_nxt   = 1'b0;
                            end
                            3'b100: begin
                                w_acc_nxt = ~r_acc;
                                w_z_nxt   = (r_acc == 4'hF);
                            end
                            3'b101: begin
                                w_acc_nxt = {r_acc[2:0], 1'b0};
                                w_c_nxt   = r_acc[3];
                                w_z_nxt   = (r_acc[2:0] == 3'd0);
                            end
                            3'b110: begin
                                w_out_data_nxt  = r_acc;
                                w_out_valid_nxt = 1'b1;
                            end
                            3'b111: begin
                                if (r_z) begin
                                    w_pc_nxt = w_pc_inc2;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HALT: ;
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    assign bus.rom_addr  = r_pc;
    assign bus.acc       = r_acc;
    assign bus.zero      = r_z;
    assign bus.carry     = r_c;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer against an ISA-level model
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.AW(3)) bus ();

    logic [3:0] rom [0:7];
    assign bus.rom_data = rom[bus.rom_addr];

    cpu_sequencer #(.AW(3), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] od;
        logic       z;
        logic       c;
        logic [2:0] pc;
    } exp_t;

    exp_t exp_q [$];
    int total = 0;
    int bad   = 0;

    int m_a, m_z, m_c, m_pc, m_h, m_od;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Interprets the ROM program instruction by instruction with integer arithmetic.
    task automatic model_run(input int max_steps, output int steps);
        exp_t e;
        int   ins;
        int   nxt;
        m_a = 0; m_z = 1; m_c = 0; m_pc = 0; m_h = 0; m_od = 0;
        steps = 0;
        while (steps < max_steps && m_h == 0) begin
            ins = int'(rom[m_pc]);
            steps++;
            if (ins == 15) begin
                m_h = 1;
            end else if (ins >= 8) begin
                m_pc = ins - 8;
            end else begin
                nxt = (m_pc + 1) % 8;
                case (ins)
                    1: begin m_c = (m_a == 15); m_a = (m_a + 1) % 16; m_z = (m_a == 0); end
                    2: begin m_c = (m_a == 0); m_a = (m_a + 15) % 16; m_z = (m_a == 0); end
                    3: begin m_a = 0; m_z = 1; m_c = 0; end
                    4: begin m_a = 15 - m_a; m_z = (m_a == 0); end
                    5: begin m_c = (m_a >= 8); m_a = (m_a * 2) % 16; m_z = (m_a == 0); end
                    6: begin
                        m_od = m_a;
                        e.od = 4'(m_a); e.z = 1'(m_z); e.c = 1'(m_c); e.pc = 3'(nxt);
                        exp_q.push_back(e);
                    end
                    7: if (m_z != 0) nxt = (m_pc + 2) % 8;
                    default: ;
                endcase
                m_pc = nxt;
            end
        end
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc", int'(bus.acc), 0);
        chk("rst_zero", int'(bus.zero), 1);
        chk("rst_carry", int'(bus.carry), 0);
        chk("rst_pc", int'(bus.rom_addr), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_out", int'({bus.out_valid, bus.out_data}), 0);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input string tag, input int max_steps, input bit freeze);
        int k;
        int n;
        int need;
        model_run(max_steps, k);
        do_reset();
        need = 2 * k + ((m_h != 0) ? 4 : 0);
        n = 0;
        while (n < need) begin
            @(negedge clk);
            if (freeze && $urandom_range(0, 3) == 0) begin
                bus.en = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end else begin
                bus.en = 1'b1;
                n++;
            end
        end
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk({tag, "_acc"}, int'(bus.acc), m_a);
        chk({tag, "_zero"}, int'(bus.zero), m_z);
        chk({tag, "_carry"}, int'(bus.carry), m_c);
        chk({tag, "_pc"}, int'(bus.rom_addr), m_pc);
        chk({tag, "_halted"}, int'(bus.halted), m_h);
        chk({tag, "_out_data"}, int'(bus.out_data), m_od);
        chk({tag, "_pending_outs"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_data=%0d expected no pulse", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", int'(bus.out_data), int'(e.od));
                chk("out_acc", int'(bus.acc), int'(e.od));
                chk("out_zero", int'(bus.zero), int'(e.z));
                chk("out_carry", int'(bus.carry), int'(e.c));
                chk("out_pc", int'(bus.rom_addr), int'(e.pc));
            end
        end
    end

    initial begin
        bus.en = 1'b0;
        rom = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

        rom = '{4'd1, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        run_prog("real_rom", 20, 1'b0);

        rom = '{4'd3, 4'd2, 4'd6, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
        run_prog("dec_out", 20, 1'b0);
        run_prog("dec_out_frz", 20, 1'b1);

        rom = '{4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_prog("inc_wrap", 31, 1'b0);

        rom = '{4'd3, 4'd7, 4'd1, 4'd6, 4'd15, 4'd0, 4'd0, 4'd0};
        run_prog("skz_taken", 20, 1'b0);
        run_prog("skz_taken_frz", 20, 1'b1);
        rom[0] = 4'd1;
        run_prog("skz_not", 20, 1'b0);

        rom = '{4'd3, 4'd14, 4'd6, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0};
        run_prog("skz_wrap6", 11, 1'b0);
        rom = '{4'd3, 4'd14, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
        run_prog("skz_wrap7", 12, 1'b0);

        // Reset between the FETCH and EXEC edges of the second INC.
        rom = '{4'd1, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        do_reset();
        repeat (3) begin
            @(negedge clk);
            bus.en = 1'b1;
        end
        @(negedge clk);
        chk("pre_rst_acc", int'(bus.acc), 1);
        chk("pre_rst_pc", int'(bus.rom_addr), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", int'(bus.acc), 0);
        chk("mid_rst_pc", int'(bus.rom_addr), 0);
        chk("mid_rst_zero", int'(bus.zero), 1);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_prog("rst_restart", 9, 1'b0);

        for (int p = 0; p < 60; p++) begin
            for (int a = 0; a < 8; a++) rom[a] = 4'($urandom_range(0, 15));
            run_prog("rand", 30, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
